// File: rtl/axi_interface_master.sv
// AXI4 master with exactly one transaction in flight: a core request becomes one AW/W/B
// or AR/R burst, and the burst's response and error status are reported back to the core.
module axi_interface_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_BITS    = 4,
  parameter int LEN_BITS   = 8,
  parameter int SIZE_BITS  = 3
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  // core request
  input  logic                    i_req,
  output logic                    o_req_ready,
  input  logic                    i_we,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  input  logic [LEN_BITS-1:0]     i_len,
  input  logic [SIZE_BITS-1:0]    i_size,
  input  logic [1:0]              i_burst,
  input  logic [ID_BITS-1:0]      i_id,
  // core write / read data
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_wstrb,
  input  logic                    i_wvalid,
  output logic                    o_wready,
  output logic [DATA_WIDTH-1:0]   o_rdata,
  output logic                    o_rvalid,
  output logic                    o_rlast,
  input  logic                    i_rready,
  output logic                    o_done,
  output logic [1:0]              o_resp,
  output logic                    o_err,
  // AW
  output logic [ID_BITS-1:0]      awid,
  output logic [ADDR_WIDTH-1:0]   awaddr,
  output logic [LEN_BITS-1:0]     awlen,
  output logic [SIZE_BITS-1:0]    awsize,
  output logic [1:0]              awburst,
  output logic                    awvalid,
  input  logic                    awready,
  // W
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    wlast,
  output logic                    wvalid,
  input  logic                    wready,
  // B
  input  logic [ID_BITS-1:0]      bid,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready,
  // AR
  output logic [ID_BITS-1:0]      arid,
  output logic [ADDR_WIDTH-1:0]   araddr,
  output logic [LEN_BITS-1:0]     arlen,
  output logic [SIZE_BITS-1:0]    arsize,
  output logic [1:0]              arburst,
  output logic                    arvalid,
  input  logic                    arready,
  // R
  input  logic [ID_BITS-1:0]      rid,
  input  logic [DATA_WIDTH-1:0]   rdata,
  input  logic [1:0]              rresp,
  input  logic                    rlast,
  input  logic                    rvalid,
  output logic                    rready
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_AW    = 3'd1;
  localparam logic [2:0] ST_WDATA = 3'd2;
  localparam logic [2:0] ST_WRESP = 3'd3;
  localparam logic [2:0] ST_AR    = 3'd4;
  localparam logic [2:0] ST_RDATA = 3'd5;

  logic [2:0]            state_r;
  logic [2:0]            state_next_s;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [LEN_BITS-1:0]   len_r;
  logic [SIZE_BITS-1:0]  size_r;
  logic [1:0]            burst_r;
  logic [ID_BITS-1:0]    id_r;
  logic [LEN_BITS-1:0]   beat_cnt_r;
  logic                  done_r;
  logic [1:0]            resp_r;
  logic                  err_r;

  logic accept_s;
  logic aw_hs_s;
  logic w_hs_s;
  logic b_hs_s;
  logic ar_hs_s;
  logic r_hs_s;
  logic cnt_at_len_s;
  logic r_err_s;

  assign accept_s     = i_req & o_req_ready;
  assign aw_hs_s      = awvalid & awready;
  assign w_hs_s       = wvalid & wready;
  assign b_hs_s       = bready & bvalid;
  assign ar_hs_s      = arvalid & arready;
  assign r_hs_s       = o_rvalid & rready;
  assign cnt_at_len_s = (beat_cnt_r == len_r);
  // A beat is bad if its ID is foreign or rlast disagrees with the expected final beat.
  assign r_err_s      = (rid != id_r) | (rlast != cnt_at_len_s);

  assign awid    = id_r;
  assign awaddr  = addr_r;
  assign awlen   = len_r;
  assign awsize  = size_r;
  assign awburst = burst_r;
  assign arid    = id_r;
  assign araddr  = addr_r;
  assign arlen   = len_r;
  assign arsize  = size_r;
  assign arburst = burst_r;
  assign wdata   = i_wdata;
  assign wstrb   = i_wstrb;
  assign o_rdata = rdata;
  assign o_rlast = rlast;
  assign o_done  = done_r;
  assign o_resp  = resp_r;
  assign o_err   = err_r;

  // Channel valid/ready decode from the current state
  always_comb begin
    o_req_ready = 1'b0;
    awvalid     = 1'b0;
    wvalid      = 1'b0;
    o_wready    = 1'b0;
    wlast       = 1'b0;
    bready      = 1'b0;
    arvalid     = 1'b0;
    rready      = 1'b0;
    o_rvalid    = 1'b0;
    case (state_r)
      ST_IDLE:  o_req_ready = ~done_r;
      ST_AW:    awvalid = 1'b1;
      ST_WDATA: begin
        wvalid   = i_wvalid;
        o_wready = wready;
        wlast    = cnt_at_len_s;
      end
      ST_WRESP: bready = 1'b1;
      ST_AR:    arvalid = 1'b1;
      ST_RDATA: begin
        rready   = i_rready;
        o_rvalid = rvalid;
      end
      default:  o_req_ready = 1'b0;
    endcase
  end

  // Next-state selection
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_next_s = i_we ? ST_AW : ST_AR;
        else          state_next_s = ST_IDLE;
      end
      ST_AW: begin
        if (aw_hs_s) state_next_s = ST_WDATA;
        else         state_next_s = ST_AW;
      end
      ST_WDATA: begin
        if (w_hs_s && cnt_at_len_s) state_next_s = ST_WRESP;
        else                        state_next_s = ST_WDATA;
      end
      ST_WRESP: begin
        if (b_hs_s) state_next_s = ST_IDLE;
        else        state_next_s = ST_WRESP;
      end
      ST_AR: begin
        if (ar_hs_s) state_next_s = ST_RDATA;
        else         state_next_s = ST_AR;
      end
      // A read only ends on rlast, even if it arrives early or late.
      ST_RDATA: begin
        if (r_hs_s && rlast) state_next_s = ST_IDLE;
        else                 state_next_s = ST_RDATA;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State register and attribute capture at request accept
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_r <= ST_IDLE;
      addr_r  <= {ADDR_WIDTH{1'b0}};
      len_r   <= {LEN_BITS{1'b0}};
      size_r  <= {SIZE_BITS{1'b0}};
      burst_r <= 2'b00;
      id_r    <= {ID_BITS{1'b0}};
    end else begin
      state_r <= state_next_s;
      if (accept_s) begin
        addr_r  <= i_addr;
        len_r   <= i_len;
        size_r  <= i_size;
        burst_r <= i_burst;
        id_r    <= i_id;
      end
    end
  end

  // Beat counter; saturates so a 256-beat burst never wraps back to zero
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      beat_cnt_r <= {LEN_BITS{1'b0}};
    end else if (aw_hs_s || ar_hs_s) begin
      beat_cnt_r <= {LEN_BITS{1'b0}};
    end else if ((w_hs_s || r_hs_s) && (beat_cnt_r != {LEN_BITS{1'b1}})) begin
      beat_cnt_r <= beat_cnt_r + LEN_BITS'(1);
    end
  end

  // Completion pulse plus response/error folding
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      done_r <= 1'b0;
      resp_r <= 2'b00;
      err_r  <= 1'b0;
    end else begin
      done_r <= b_hs_s | (r_hs_s & rlast);
      if (accept_s) begin
        resp_r <= 2'b00;
        err_r  <= 1'b0;
      end else if (b_hs_s) begin
        resp_r <= bresp;
        err_r  <= (bid != id_r);
      end else if (r_hs_s) begin
        resp_r <= (rresp > resp_r) ? rresp : resp_r;
        err_r  <= err_r | r_err_s;
      end
    end
  end

endmodule

// File: tb/tb_axi_interface_master.sv
// Directed-plus-random bench for axi_interface_master: the bench plays core and AXI slave,
// and predicts beats, responses and error flags from the protocol rules.
module tb_axi_interface_master;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        i_req, o_req_ready, i_we;
  logic [31:0] i_addr;
  logic [7:0]  i_len;
  logic [2:0]  i_size;
  logic [1:0]  i_burst;
  logic [3:0]  i_id;
  logic [31:0] i_wdata;
  logic [3:0]  i_wstrb;
  logic        i_wvalid, o_wready;
  logic [31:0] o_rdata;
  logic        o_rvalid, o_rlast, i_rready, o_done, o_err;
  logic [1:0]  o_resp;
  logic [3:0]  awid, arid, bid, rid;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        awvalid, awready, arvalid, arready;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready, bvalid, bready, rlast, rvalid, rready;

  int checks = 0;
  int failures = 0;

  logic [31:0] wr_data [0:299];
  logic [3:0]  wr_strb [0:299];
  logic [31:0] rd_data [0:299];
  logic [1:0]  rd_resp [0:299];
  logic [3:0]  rd_id   [0:299];

  always #5 clk_i = ~clk_i;

  axi_interface_master dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .i_req(i_req), .o_req_ready(o_req_ready), .i_we(i_we),
    .i_addr(i_addr), .i_len(i_len), .i_size(i_size), .i_burst(i_burst), .i_id(i_id),
    .i_wdata(i_wdata), .i_wstrb(i_wstrb), .i_wvalid(i_wvalid), .o_wready(o_wready),
    .o_rdata(o_rdata), .o_rvalid(o_rvalid), .o_rlast(o_rlast), .i_rready(i_rready),
    .o_done(o_done), .o_resp(o_resp), .o_err(o_err),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    i_req = 1'b0; i_we = 1'b0; i_addr = 32'h0; i_len = 8'h0; i_size = 3'd0; i_burst = 2'b00;
    i_id = 4'h0; i_wdata = 32'h0; i_wstrb = 4'h0; i_wvalid = 1'b0; i_rready = 1'b0;
    awready = 1'b0; wready = 1'b0; bid = 4'h0; bresp = 2'b00; bvalid = 1'b0; arready = 1'b0;
    rid = 4'h0; rdata = 32'h0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;
  endtask

  task automatic fill_wr();
    for (int k = 0; k < 300; k++) begin
      wr_data[k] = $urandom;
      wr_strb[k] = 4'($urandom_range(0, 15));
    end
  endtask

  task automatic fill_rd(input logic [3:0] id, input bit rnd_resp);
    for (int k = 0; k < 300; k++) begin
      rd_data[k] = $urandom;
      rd_resp[k] = rnd_resp ? 2'($urandom_range(0, 3)) : 2'b00;
      rd_id[k]   = id;
    end
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!o_req_ready && n < 20) begin
      tick();
      n++;
    end
    check("req_ready", 64'(o_req_ready), 64'(1'b1));
  endtask

  task automatic finish_txn(input string tag);
    tick();
    check({tag, "_done_one_cycle"}, 64'(o_done), 64'(1'b0));
    check({tag, "_ready_after_done"}, 64'(o_req_ready), 64'(1'b1));
  endtask

  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                          input logic [1:0] bresp_v, input logic [3:0] bid_v,
                          input bit stall, input bit early_b);
    int n, idx;
    bit hs;
    wait_ready();
    i_req = 1'b1; i_we = 1'b1; i_addr = addr; i_len = 8'(len); i_size = 3'd2;
    i_burst = 2'b01; i_id = id;
    if (early_b) begin
      bvalid = 1'b1; bid = bid_v; bresp = bresp_v;
    end
    tick();
    // scramble the request bus so only captured attributes can reach AW
    i_req = 1'b0; i_addr = ~addr; i_len = ~8'(len); i_id = ~id; i_size = 3'd0; i_burst = 2'b10;
    n = 0; hs = 1'b0;
    while (!hs && n < 50) begin
      awready = (early_b && n < 4) ? 1'b0 : (stall ? 1'($urandom_range(0, 1)) : 1'b1);
      #1;
      check("aw_valid", 64'(awvalid), 64'(1'b1));
      check("aw_addr", 64'(awaddr), 64'(addr));
      check("aw_len", 64'(awlen), 64'(len));
      check("aw_id", 64'(awid), 64'(id));
      check("aw_size", 64'(awsize), 64'(3'd2));
      check("aw_burst", 64'(awburst), 64'(2'b01));
      check("ar_quiet", 64'(arvalid), 64'(1'b0));
      if (early_b) check("b_pending_aw", 64'(bready), 64'(1'b0));
      hs = awvalid && awready;
      tick();
      n++;
    end
    check("aw_handshake", 64'(hs), 64'(1'b1));
    awready = 1'b0;
    idx = 0; n = 0;
    while (idx <= len && n < 3000) begin
      i_wvalid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      wready   = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      i_wdata  = wr_data[idx];
      i_wstrb  = wr_strb[idx];
      #1;
      check("w_valid", 64'(wvalid), 64'(i_wvalid));
      check("w_core_ready", 64'(o_wready), 64'(wready));
      check("w_data", 64'(wdata), 64'(wr_data[idx]));
      check("w_strb", 64'(wstrb), 64'(wr_strb[idx]));
      check("w_last", 64'(wlast), 64'(idx == len));
      if (early_b) check("b_pending_w", 64'(bready), 64'(1'b0));
      if (i_wvalid && wready) idx++;
      tick();
      n++;
    end
    check("w_beats", 64'(idx), 64'(len + 1));
    i_wvalid = 1'b1; wready = 1'b1;
    n = 0; hs = 1'b0;
    while (!hs && n < 50) begin
      if (!early_b) begin
        bvalid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        bid = bid_v; bresp = bresp_v;
      end
      #1;
      check("w_no_extra_beat", 64'(wvalid), 64'(1'b0));
      check("w_core_ready_off", 64'(o_wready), 64'(1'b0));
      check("b_ready", 64'(bready), 64'(1'b1));
      check("w_no_early_done", 64'(o_done), 64'(1'b0));
      hs = bvalid && bready;
      tick();
      n++;
    end
    check("b_handshake", 64'(hs), 64'(1'b1));
    bvalid = 1'b0; i_wvalid = 1'b0; wready = 1'b0;
    #1;
    check("w_done", 64'(o_done), 64'(1'b1));
    check("w_resp", 64'(o_resp), 64'(bresp_v));
    check("w_err", 64'(o_err), 64'(bid_v != id));
    check("w_no_accept_on_done", 64'(o_req_ready), 64'(1'b0));
    finish_txn("w");
  endtask

  // t is the beat index on which the slave raises rlast
  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                         input int t, input bit stall, input int rst_beat);
    int n, idx;
    bit hs, fin;
    logic [1:0] exp_resp, run_max;
    logic exp_err;
    exp_err = (t != len);
    exp_resp = 2'b00;
    for (int k = 0; k <= t; k++) begin
      if (rd_id[k] != id) exp_err = 1'b1;
      if (rd_resp[k] > exp_resp) exp_resp = rd_resp[k];
    end
    wait_ready();
    i_req = 1'b1; i_we = 1'b0; i_addr = addr; i_len = 8'(len); i_size = 3'd2;
    i_burst = 2'b01; i_id = id;
    tick();
    i_req = 1'b0; i_addr = ~addr; i_len = ~8'(len); i_id = ~id; i_burst = 2'b00;
    n = 0; hs = 1'b0;
    while (!hs && n < 50) begin
      arready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      check("ar_valid", 64'(arvalid), 64'(1'b1));
      check("ar_addr", 64'(araddr), 64'(addr));
      check("ar_len", 64'(arlen), 64'(len));
      check("ar_id", 64'(arid), 64'(id));
      check("aw_quiet", 64'(awvalid), 64'(1'b0));
      hs = arvalid && arready;
      tick();
      n++;
    end
    check("ar_handshake", 64'(hs), 64'(1'b1));
    arready = 1'b0;
    idx = 0; n = 0; fin = 1'b0; run_max = 2'b00;
    while (!fin && n < 3000) begin
      if (idx == rst_beat) begin
        rvalid = 1'b1; i_rready = 1'b1; rlast = 1'b0; rdata = rd_data[idx];
        rresp = rd_resp[idx]; rid = rd_id[idx];
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1; i_wvalid = 1'b1;
        #1;
        check("rst_awvalid", 64'(awvalid), 64'(1'b0));
        check("rst_wvalid", 64'(wvalid), 64'(1'b0));
        check("rst_bready", 64'(bready), 64'(1'b0));
        check("rst_arvalid", 64'(arvalid), 64'(1'b0));
        check("rst_rready", 64'(rready), 64'(1'b0));
        check("rst_rvalid", 64'(o_rvalid), 64'(1'b0));
        check("rst_done", 64'(o_done), 64'(1'b0));
        check("rst_err", 64'(o_err), 64'(1'b0));
        check("rst_resp", 64'(o_resp), 64'(2'b00));
        check("rst_req_ready", 64'(o_req_ready), 64'(1'b1));
        for (int k = 0; k < 3; k++) begin
          tick();
          check("rst_no_done", 64'(o_done), 64'(1'b0));
        end
        rvalid = 1'b0; i_rready = 1'b0; i_wvalid = 1'b0;
        return;
      end
      rvalid   = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      i_rready = stall ? 1'(n % 2) : 1'b1;
      rdata = rd_data[idx]; rresp = rd_resp[idx]; rid = rd_id[idx]; rlast = (idx == t);
      #1;
      check("r_valid", 64'(o_rvalid), 64'(rvalid));
      check("r_data", 64'(o_rdata), 64'(rd_data[idx]));
      check("r_last", 64'(o_rlast), 64'(idx == t));
      check("r_ready", 64'(rready), 64'(i_rready));
      check("r_resp_running", 64'(o_resp), 64'(run_max));
      check("r_no_early_done", 64'(o_done), 64'(1'b0));
      if (rvalid && i_rready) begin
        if (rd_resp[idx] > run_max) run_max = rd_resp[idx];
        if (idx == t) fin = 1'b1;
        idx++;
      end
      tick();
      n++;
    end
    check("r_finished", 64'(fin), 64'(1'b1));
    rvalid = 1'b1; i_rready = 1'b1; rlast = 1'b0;
    #1;
    check("r_done", 64'(o_done), 64'(1'b1));
    check("r_resp", 64'(o_resp), 64'(exp_resp));
    check("r_err", 64'(o_err), 64'(exp_err));
    check("r_beats", 64'(idx), 64'(t + 1));
    check("r_rready_off", 64'(rready), 64'(1'b0));
    check("r_rvalid_off", 64'(o_rvalid), 64'(1'b0));
    check("r_no_accept_on_done", 64'(o_req_ready), 64'(1'b0));
    rvalid = 1'b0; i_rready = 1'b0;
    finish_txn("r");
  endtask

  initial begin
    logic [3:0] id_v, bid_v;
    int len_v, t_v;
    rst_ni = 1'b0;
    idle_inputs();
    tick();
    tick();
    i_wvalid = 1'b1; i_rready = 1'b1; rvalid = 1'b1; bvalid = 1'b1;
    #1;
    check("reset_awvalid", 64'(awvalid), 64'(1'b0));
    check("reset_wvalid", 64'(wvalid), 64'(1'b0));
    check("reset_bready", 64'(bready), 64'(1'b0));
    check("reset_arvalid", 64'(arvalid), 64'(1'b0));
    check("reset_rready", 64'(rready), 64'(1'b0));
    check("reset_rvalid", 64'(o_rvalid), 64'(1'b0));
    check("reset_done", 64'(o_done), 64'(1'b0));
    check("reset_err", 64'(o_err), 64'(1'b0));
    check("reset_resp", 64'(o_resp), 64'(2'b00));
    check("reset_req_ready", 64'(o_req_ready), 64'(1'b1));
    idle_inputs();
    rst_ni = 1'b1;
    tick();

    // single write, then a stalled 4-beat burst
    fill_wr();
    wr_data[0] = 32'hDEAD_BEEF;
    wr_strb[0] = 4'hF;
    do_write(4'd1, 32'h0000_0100, 0, 2'b00, 4'd1, 1'b0, 1'b0);
    fill_wr();
    do_write(4'd2, 32'h0000_2000, 3, 2'b00, 4'd2, 1'b1, 1'b0);
    // foreign bid with bvalid raised long before WRESP
    fill_wr();
    do_write(4'd3, 32'h0000_3000, 1, 2'b01, 4'd5, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      fill_wr();
      id_v  = 4'($urandom_range(0, 15));
      bid_v = ($urandom_range(0, 2) == 0) ? id_v + 4'd1 : id_v;
      do_write(id_v, $urandom, $urandom_range(0, 15), 2'($urandom_range(0, 3)), bid_v,
               1'b1, 1'($urandom_range(0, 1)));
    end
    fill_wr();
    do_write(4'd9, 32'h0001_0000, 255, 2'b00, 4'd9, 1'b0, 1'b0);

    // 8-beat read with SLVERR on beat 5
    fill_rd(4'd4, 1'b0);
    rd_resp[5] = 2'b10;
    do_read(4'd4, 32'h0000_4000, 7, 7, 1'b1, -1);
    // rlast early on beat 2 of a 4-beat read, then rlast one beat late
    fill_rd(4'd6, 1'b0);
    do_read(4'd6, 32'h0000_5000, 3, 2, 1'b0, -1);
    fill_rd(4'd7, 1'b1);
    do_read(4'd7, 32'h0000_6000, 2, 3, 1'b1, -1);
    for (int i = 0; i < 4; i++) begin
      id_v  = 4'($urandom_range(0, 15));
      len_v = $urandom_range(0, 12);
      fill_rd(id_v, 1'b1);
      if ($urandom_range(0, 2) == 0) rd_id[$urandom_range(0, len_v)] = id_v ^ 4'h2;
      t_v = len_v;
      if ($urandom_range(0, 3) == 0) t_v = len_v + 1;
      do_read(id_v, $urandom, len_v, t_v, 1'b1, -1);
    end
    fill_rd(4'd8, 1'b0);
    do_read(4'd8, 32'h0002_0000, 255, 255, 1'b0, -1);

    // reset during beat 2 of an 8-beat read with sticky status already set
    fill_rd(4'd10, 1'b0);
    rd_resp[0] = 2'b11;
    rd_id[1]   = 4'd11;
    do_read(4'd10, 32'h0000_7000, 7, 7, 1'b0, 2);
    fill_wr();
    do_write(4'd12, 32'h0000_8000, 2, 2'b00, 4'd12, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
